// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus bundle.
// Purpose : groups the instruction-memory, decode-handshake and redirect
//           signals of if_fetch_unit into one port.
// Signals : imem_req/imem_addr      read request to instruction memory
//           imem_rvalid/imem_rdata  in-order read response
//           instr_valid/instr_ready/instr_out/instr_pc  handshake to IF/ID
//           redirect_sel/br_pc/cond_addr26/cond_addr19/br_reg_target
//                                   branch redirect from decode/execute
// Modports: master = fetch unit, slave = memory/decode/branch side.
interface if_fetch_unit_if;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_out;
   logic [63:0] instr_pc;
   logic [1:0]  redirect_sel;
   logic [63:0] br_pc;
   logic [25:0] cond_addr26;
   logic [18:0] cond_addr19;
   logic [63:0] br_reg_target;

   modport master (
      output imem_req, imem_addr, instr_valid, instr_out, instr_pc,
      input  imem_rvalid, imem_rdata, instr_ready, redirect_sel, br_pc,
             cond_addr26, cond_addr19, br_reg_target
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr_out, instr_pc,
      output imem_rvalid, imem_rdata, instr_ready, redirect_sel, br_pc,
             cond_addr26, cond_addr19, br_reg_target
   );
endinterface

// File: rtl/if_fetch_unit.sv
// LEGv8 instruction fetch stage.
// Purpose : holds the PC, issues single-outstanding reads to instruction
//           memory, buffers returned words (with their PC) in a 2-entry
//           FIFO and presents them to decode over valid/ready. Computes
//           branch redirect targets and flushes wrong-path state.
// Ports   : clk, reset (synchronous, active-high)
//           bus (if_fetch_unit_if.master) - memory, decode and redirect
//
// state      | meaning
// -----------+--------------------------------------------------------
// RUN        | normal fetch, requests may issue
// FLUSH_WAIT | redirected while a read was in flight; drop its response
module if_fetch_unit #(
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter logic [31:0] NOP_INSTR = 32'hFFFF_FFFF
) (
   input logic             clk,
   input logic             reset,
   if_fetch_unit_if.master bus
);
   typedef enum logic {RUN = 1'b0, FLUSH_WAIT = 1'b1} state_t;

   state_t      state, state_nxt;
   logic [63:0] pc, req_pc, target;
   logic        outstanding;
   logic [31:0] fifo_instr [2];
   logic [63:0] fifo_pc [2];
   logic        wr_ptr, rd_ptr;
   logic [1:0]  count;
   logic        redirect, rsp, push, pop, issue, instr_valid;
   logic [2:0]  occupancy;

   assign redirect    = bus.redirect_sel != 2'b00;
   assign rsp         = outstanding && bus.imem_rvalid;
   assign instr_valid = count != 2'd0;
   assign pop         = instr_valid && bus.instr_ready;
   assign push        = (state == RUN) && !redirect && rsp;

   // Slots committed after this cycle: FIFO after the pop plus the word in
   // flight (which lands this cycle if rvalid is up). Counting the pop keeps
   // one instruction per cycle; counting the in-flight word keeps a push
   // from ever reaching a full FIFO.
   assign occupancy = {1'b0, count} - {2'b00, pop} + {2'b00, outstanding};

   always_comb begin
      target = pc;
      case (bus.redirect_sel)
         2'b01:   target = bus.br_pc + {{36{bus.cond_addr26[25]}}, bus.cond_addr26, 2'b00};
         2'b11:   target = bus.br_pc + {{43{bus.cond_addr19[18]}}, bus.cond_addr19, 2'b00};
         2'b10:   target = bus.br_reg_target;
         default: target = pc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= RUN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (redirect || state == FLUSH_WAIT)
         state_nxt = (outstanding && !bus.imem_rvalid) ? FLUSH_WAIT : RUN;
   end

   always_comb begin
      issue = 1'b0;
      if (state == RUN && !reset && !redirect &&
          (!outstanding || bus.imem_rvalid) && occupancy < 3'd2)
         issue = 1'b1;
   end

   assign bus.imem_req  = issue;
   assign bus.imem_addr = pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc          <= RESET_PC;
         req_pc      <= 64'h0;
         outstanding <= 1'b0;
         count       <= 2'd0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
      end else if (redirect) begin
         pc          <= target;
         // a response arriving now is the stale one; otherwise it is still due
         outstanding <= outstanding && !bus.imem_rvalid;
         count       <= 2'd0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
      end else begin
         if (issue) begin
            pc     <= pc + 64'd4;
            req_pc <= pc;
         end
         if (issue)                outstanding <= 1'b1;
         else if (bus.imem_rvalid) outstanding <= 1'b0;
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr[wr_ptr] <= bus.imem_rdata;
         fifo_pc[wr_ptr]    <= req_pc;
      end
   end

   assign bus.instr_valid = instr_valid;
   assign bus.instr_out   = instr_valid ? fifo_instr[rd_ptr] : NOP_INSTR;
   assign bus.instr_pc    = instr_valid ? fifo_pc[rd_ptr] : 64'h0;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed cycle-by-cycle vectors against a
// simple latency-programmable instruction memory.
module tb_if_fetch_unit;
   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;
   int   lat;
   logic        mem_pend;
   int          mem_cnt;
   logic [63:0] mem_addr;

   if_fetch_unit_if bus ();

   if_fetch_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input logic [63:0] a);
      return 32'hA500_0000 ^ a[31:0];
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #2;
   endtask

   // Memory: request seen in cycle N answers in cycle N+lat.
   initial begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
      mem_pend = 1'b0;
      mem_cnt  = 0;
      mem_addr = 64'h0;
      forever begin
         @(negedge clk);
         if (!reset && bus.imem_req) begin
            mem_pend = 1'b1;
            mem_addr = bus.imem_addr;
            mem_cnt  = lat;
         end
         @(posedge clk);
         #1;
         bus.imem_rvalid = 1'b0;
         if (mem_pend) begin
            if (mem_cnt <= 1) begin
               bus.imem_rvalid = 1'b1;
               bus.imem_rdata  = pat(mem_addr);
               mem_pend = 1'b0;
            end else begin
               mem_cnt--;
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      lat   = 1;
      bus.instr_ready   = 1'b1;
      bus.redirect_sel  = 2'b00;
      bus.br_pc         = 64'h0;
      bus.cond_addr26   = 26'h0;
      bus.cond_addr19   = 19'h0;
      bus.br_reg_target = 64'h0;

      adv();
      adv();
      @(negedge clk);
      check("rst_valid", bus.instr_valid, 1'b0);
      check("rst_out",   bus.instr_out, 32'hFFFF_FFFF);
      check("rst_pc",    bus.instr_pc, 64'h0);
      check("rst_req",   bus.imem_req, 1'b0);

      // free run, L=1
      for (int c = 0; c < 10; c++) begin
         adv();
         if (c == 0) reset = 1'b0;
         @(negedge clk);
         check("run_req",  bus.imem_req, 1'b1);
         check("run_addr", bus.imem_addr, 64'(4 * c));
         if (c >= 2) begin
            check("run_valid", bus.instr_valid, 1'b1);
            check("run_pc",    bus.instr_pc, 64'(4 * (c - 2)));
            check("run_out",   bus.instr_out, pat(64'(4 * (c - 2))));
         end else begin
            check("run_nvalid", bus.instr_valid, 1'b0);
         end
      end

      // stall 5 cycles: head frozen at 0x20, no requests
      for (int s = 0; s < 5; s++) begin
         adv();
         bus.instr_ready = 1'b0;
         @(negedge clk);
         check("stall_valid", bus.instr_valid, 1'b1);
         check("stall_pc",    bus.instr_pc, 64'h20);
         check("stall_req",   bus.imem_req, 1'b0);
      end
      for (int k = 0; k < 6; k++) begin
         adv();
         bus.instr_ready = 1'b1;
         @(negedge clk);
         check("rel_req",  bus.imem_req, 1'b1);
         check("rel_addr", bus.imem_addr, 64'(40 + 4 * k));
         check("rel_pc",   bus.instr_pc, 64'(32 + 4 * k));
         check("rel_out",  bus.instr_out, pat(64'(32 + 4 * k)));
      end

      // sel=01, coincident with rvalid: 0x100 - 8 = 0xF8
      adv();
      bus.redirect_sel = 2'b01;
      bus.br_pc        = 64'h100;
      bus.cond_addr26  = 26'h3FF_FFFE;
      @(negedge clk);
      check("r26_req0", bus.imem_req, 1'b0);
      adv();
      bus.redirect_sel = 2'b00;
      @(negedge clk);
      check("r26_req",   bus.imem_req, 1'b1);
      check("r26_addr",  bus.imem_addr, 64'hF8);
      check("r26_flush", bus.instr_valid, 1'b0);
      adv();
      @(negedge clk);
      check("r26_nv",    bus.instr_valid, 1'b0);
      check("r26_addr2", bus.imem_addr, 64'hFC);
      adv();
      @(negedge clk);
      check("r26_valid", bus.instr_valid, 1'b1);
      check("r26_pc",    bus.instr_pc, 64'hF8);
      check("r26_out",   bus.instr_out, pat(64'hF8));

      // sel=11: 0x100 + 0x40
      adv();
      bus.redirect_sel = 2'b11;
      bus.cond_addr19  = 19'h10;
      @(negedge clk);
      check("r19_req0", bus.imem_req, 1'b0);
      adv();
      bus.redirect_sel = 2'b00;
      @(negedge clk);
      check("r19_addr",  bus.imem_addr, 64'h140);
      check("r19_flush", bus.instr_valid, 1'b0);
      adv();
      adv();
      @(negedge clk);
      check("r19_pc", bus.instr_pc, 64'h140);

      // sel=10: register target
      adv();
      bus.redirect_sel  = 2'b10;
      bus.br_reg_target = 64'h2000;
      @(negedge clk);
      check("rreg_req0", bus.imem_req, 1'b0);
      adv();
      bus.redirect_sel = 2'b00;
      @(negedge clk);
      check("rreg_addr",  bus.imem_addr, 64'h2000);
      check("rreg_flush", bus.instr_valid, 1'b0);
      adv();
      adv();
      @(negedge clk);
      check("rreg_pc", bus.instr_pc, 64'h2000);

      // redirect with a read in flight, L=3, then a second redirect in FLUSH_WAIT
      adv();
      lat = 3;
      @(negedge clk);
      check("fw_addr0", bus.imem_addr, 64'h200C);
      check("fw_pc0",   bus.instr_pc, 64'h2004);
      adv();
      bus.redirect_sel  = 2'b10;
      bus.br_reg_target = 64'h3000;
      @(negedge clk);
      check("fw_req0", bus.imem_req, 1'b0);
      adv();
      bus.redirect_sel = 2'b01;
      bus.br_pc        = 64'h3000;
      bus.cond_addr26  = 26'h4;
      @(negedge clk);
      check("fw_req1", bus.imem_req, 1'b0);
      check("fw_nv1",  bus.instr_valid, 1'b0);
      adv();
      bus.redirect_sel = 2'b00;
      @(negedge clk);
      check("fw_req2", bus.imem_req, 1'b0);
      check("fw_nv2",  bus.instr_valid, 1'b0);
      adv();
      @(negedge clk);
      check("fw_req3",  bus.imem_req, 1'b1);
      check("fw_addr3", bus.imem_addr, 64'h3010);
      check("fw_nv3",   bus.instr_valid, 1'b0);
      for (int w = 0; w < 3; w++) begin
         adv();
         @(negedge clk);
         check("fw_nvw", bus.instr_valid, 1'b0);
      end

      // reset with a word buffered and a read in flight
      adv();
      reset = 1'b1;
      bus.instr_ready = 1'b0;
      @(negedge clk);
      check("fw_pc",  bus.instr_pc, 64'h3010);
      check("fw_out", bus.instr_out, pat(64'h3010));
      adv();
      @(negedge clk);
      check("mrst_valid", bus.instr_valid, 1'b0);
      check("mrst_out",   bus.instr_out, 32'hFFFF_FFFF);
      check("mrst_pc",    bus.instr_pc, 64'h0);
      check("mrst_req",   bus.imem_req, 1'b0);
      adv();
      reset = 1'b0;
      bus.instr_ready = 1'b1;
      lat = 1;
      @(negedge clk);
      check("post_req",  bus.imem_req, 1'b1);
      check("post_addr", bus.imem_addr, 64'h0);
      check("post_nv0",  bus.instr_valid, 1'b0);
      adv();
      @(negedge clk);
      check("post_nv1",  bus.instr_valid, 1'b0);
      check("post_addr1", bus.imem_addr, 64'h4);
      adv();
      @(negedge clk);
      check("post_valid", bus.instr_valid, 1'b1);
      check("post_pc",    bus.instr_pc, 64'h0);
      check("post_out",   bus.instr_out, pat(64'h0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
